gcd_engine: RTL and testbench
=============================

GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (legal range 4..64).
REQ-002 The block SHALL have parameter BINARY, default 1, where 1 selects the Stein binary algorithm and 0 selects the subtractive algorithm.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: engine can accept an operand pair.
REQ-007 The block SHALL have ports a_in and b_in, input, WIDTH bits each: operands, treated as unsigned.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port gcd_out, output, WIDTH bits: the result.
REQ-011 The block SHALL have port cycles, output, 16 bits: ITER cycles spent on the current or last job, saturating at 16'hFFFF.

Function
REQ-012 The block SHALL use an FSM with three states, IDLE, ITER and DONE, and SHALL assert in_ready only in IDLE and out_valid only in DONE.
REQ-013 On in_valid && in_ready, the block SHALL capture A=a_in, B=b_in, shift k=0 (clog2(WIDTH+1) bits) and cycles=0, and SHALL enter ITER.
REQ-014 In ITER, each cycle SHALL increment cycles (saturating) and perform exactly one step, applying the first matching rule:
  - A==0 or B==0: result=(A|B)<<k; go to DONE.
  - A==B: result=A<<k; go to DONE.
  - BINARY=1, both even: A>>=1, B>>=1, k++.
  - BINARY=1, A even: A>>=1; B even: B>>=1.
  - BINARY=1, both odd: if A>B then A=(A-B)>>1, else B=(B-A)>>1.
  - BINARY=0: if A>B then A=A-B, else B=B-A.
REQ-015 The result SHALL never overflow WIDTH, because k only counts factors common to both inputs; the result shift SHALL be truncated to WIDTH bits.
REQ-016 With BINARY=1, latency from accept to out_valid SHALL be at most 2*WIDTH+1 cycles.
REQ-017 With BINARY=0, latency SHALL be data-dependent with no fixed bound, and a zero operand SHALL still terminate in 1 ITER cycle.
REQ-018 The gcd of (0,0) SHALL be 0.
REQ-019 In DONE, gcd_out and cycles SHALL hold stable until out_valid && out_ready.
REQ-020 On that out_valid && out_ready handshake the block SHALL return to IDLE, with in_ready high the next cycle; there is no same-cycle accept of new operands.
REQ-021 in_valid SHALL be ignored outside IDLE, and a_in and b_in SHALL be sampled only at accept.
REQ-022 gcd_out and cycles SHALL retain the last job's values through IDLE until the next accept.

Reset
REQ-023 While rst is high, the block SHALL force the state to IDLE, A=B=0, k=0, gcd_out=0, cycles=0, out_valid=0 and in_ready=0, asynchronously.
REQ-024 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-025 An rst asserted during ITER or DONE SHALL abort the job with no result delivered.

Structure
REQ-026 Shared package gcd_pkg SHALL hold the state enum (IDLE/ITER/DONE), the compare encoding (greater=0, smaller=1, equal=2) and the cycles width constant (16).
REQ-027 The one-iteration datapath (A, B, k, BINARY in; next A, B, k and a terminate flag out) SHALL be a combinational sub-module named gcd_step, instantiated once.

Verification
REQ-028 Bench case: WIDTH=16, BINARY=1, (48,18) -> gcd_out=6, cycles=6.
REQ-029 Bench case: WIDTH=16, BINARY=0, (48,18) -> gcd_out=6, cycles=5.
REQ-030 Bench case: (0,35) then (0,0), either mode -> gcd_out=35 then 0, cycles=1 each.
REQ-031 Bench case: WIDTH=8, BINARY=1, (255,255) -> gcd_out=255, cycles=1; (128,64) -> gcd_out=64, within 17 cycles.
REQ-032 Bench case: out_ready held low 10 cycles in DONE -> gcd_out/out_valid stable and in_ready=0 throughout; in_ready=1 the cycle after the handshake.
REQ-033 Bench case: rst pulsed mid-ITER on (1000,7) -> outputs zero immediately; the next job (12,8) -> gcd_out=4.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine: FSM states, the operand
// comparison encoding and the width of the cycle counter.
package gcd_pkg;

  localparam int unsigned CyclesWidth = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CmpGreater = 2'd0,
    CmpSmaller = 2'd1,
    CmpEqual   = 2'd2
  } cmp_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CyclesWidth-1:0] sat_inc(input logic [CyclesWidth-1:0] v);
    return (v == {CyclesWidth{1'b1}}) ? v : v + CyclesWidth'(1);
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One GCD iteration: given the current A, B and common power-of-two count k,
// produces the next operands, or flags termination together with the result.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter bit          BINARY = 1'b1,
  parameter int unsigned KW     = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  cmp_e             cmp;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] diff_ba;

  always_comb begin
    if (a > b) begin
      cmp = CmpGreater;
    end else if (a < b) begin
      cmp = CmpSmaller;
    end else begin
      cmp = CmpEqual;
    end
  end

  assign diff_ab = a - b;
  assign diff_ba = b - a;

  always_comb begin
    a_nxt  = a;
    b_nxt  = b;
    k_nxt  = k;
    done   = 1'b0;
    // Covers both exits: with one operand zero A|B is the other, with A==B it is A.
    result = (a | b) << k;
    if (a == '0 || b == '0) begin
      done = 1'b1;
    end else if (cmp == CmpEqual) begin
      done = 1'b1;
    end else if (BINARY) begin
      if (!a[0] && !b[0]) begin
        a_nxt = a >> 1;
        b_nxt = b >> 1;
        k_nxt = k + KW'(1);
      end else if (!a[0]) begin
        a_nxt = a >> 1;
      end else if (!b[0]) begin
        b_nxt = b >> 1;
      end else if (cmp == CmpGreater) begin
        a_nxt = diff_ab >> 1;
      end else begin
        b_nxt = diff_ba >> 1;
      end
    end else begin
      if (cmp == CmpGreater) begin
        a_nxt = diff_ab;
      end else begin
        b_nxt = diff_ba;
      end
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine with valid/ready handshakes on both sides; one step of
// Stein's binary or the subtractive algorithm per clock.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter bit          BINARY = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a_in,
  input  logic [WIDTH-1:0]       b_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       gcd_out,
  output logic [CyclesWidth-1:0] cycles
);

  localparam int unsigned KW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [KW-1:0]    k_q;

  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [KW-1:0]    k_nxt;
  logic             step_done;
  logic [WIDTH-1:0] step_result;

  gcd_step #(
    .WIDTH  (WIDTH),
    .BINARY (BINARY),
    .KW     (KW)
  ) u_step (
    .a      (a_q),
    .b      (b_q),
    .k      (k_q),
    .a_nxt  (a_nxt),
    .b_nxt  (b_nxt),
    .k_nxt  (k_nxt),
    .done   (step_done),
    .result (step_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      gcd_out   <= '0;
      cycles    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            a_q      <= a_in;
            b_q      <= b_in;
            k_q      <= '0;
            cycles   <= '0;
            in_ready <= 1'b0;
            state_q  <= StIter;
          end else begin
            in_ready <= 1'b1;
          end
        end
        StIter: begin
          cycles <= sat_inc(cycles);
          if (step_done) begin
            gcd_out   <= step_result;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else begin
            a_q <= a_nxt;
            b_q <= b_nxt;
            k_q <= k_nxt;
          end
        end
        StDone: begin
          // No same-cycle accept: in_ready comes up only after the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: three instances (16-bit binary, 16-bit
// subtractive, 8-bit binary) share clock and reset.
module tb_gcd_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid [3];
  logic        out_ready[3];
  logic [15:0] a_in     [3];
  logic [15:0] b_in     [3];

  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [15:0] g0, g1, c0, c1, c2;
  logic [7:0]  g2;

  logic        rdy[3];
  logic        vld[3];
  logic [15:0] res[3];
  logic [15:0] cyc[3];

  always_comb begin
    rdy[0] = ir0;
    rdy[1] = ir1;
    rdy[2] = ir2;
    vld[0] = ov0;
    vld[1] = ov1;
    vld[2] = ov2;
    res[0] = g0;
    res[1] = g1;
    res[2] = {8'h00, g2};
    cyc[0] = c0;
    cyc[1] = c1;
    cyc[2] = c2;
  end

  gcd_engine #(.WIDTH(16), .BINARY(1'b1)) u_bin16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir0),
    .a_in(a_in[0]), .b_in(b_in[0]), .out_valid(ov0), .out_ready(out_ready[0]),
    .gcd_out(g0), .cycles(c0)
  );

  gcd_engine #(.WIDTH(16), .BINARY(1'b0)) u_sub16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir1),
    .a_in(a_in[1]), .b_in(b_in[1]), .out_valid(ov1), .out_ready(out_ready[1]),
    .gcd_out(g1), .cycles(c1)
  );

  gcd_engine #(.WIDTH(8), .BINARY(1'b1)) u_bin8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(ir2),
    .a_in(a_in[2][7:0]), .b_in(b_in[2][7:0]), .out_valid(ov2), .out_ready(out_ready[2]),
    .gcd_out(g2), .cycles(c2)
  );

  typedef struct {
    int          inst;
    logic [15:0] gcd;
    int          cyc;   // negative: cycle count not checked
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x = a;
    logic [15:0] y = b;
    logic [15:0] t;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Offers one operand pair; after the accept edge in_valid stays high with junk
  // operands so that anything sampled outside IDLE corrupts the result.
  task automatic drive(input int inst, input logic [15:0] a, input logic [15:0] b,
                       input bit push, input int exp_cyc);
    int          n = 0;
    logic [15:0] am = (inst == 2) ? (a & 16'h00FF) : a;
    logic [15:0] bm = (inst == 2) ? (b & 16'h00FF) : b;
    exp_t        e;
    while (!rdy[inst] && n < 100) begin
      tick();
      n++;
    end
    check_eq($sformatf("in_ready_wait[%0d]", inst), rdy[inst], 1);
    in_valid[inst] = 1'b1;
    a_in[inst]     = am;
    b_in[inst]     = bm;
    tick();
    a_in[inst] = 16'($urandom);
    b_in[inst] = 16'($urandom);
    if (push) begin
      e.inst = inst;
      e.gcd  = ref_gcd(am, bm);
      e.cyc  = exp_cyc;
      sb.push_back(e);
    end
  endtask

  task automatic collect(input int inst, input int hold);
    int   n = 0;
    int   w = (inst == 2) ? 8 : 16;
    exp_t e;
    while (!vld[inst] && n < 3000) begin
      tick();
      n++;
    end
    check_eq($sformatf("out_valid_wait[%0d]", inst), vld[inst], 1);
    in_valid[inst] = 1'b0;
    check_eq($sformatf("sb_nonempty[%0d]", inst), sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq($sformatf("sb_inst[%0d]", inst), e.inst, inst);
      check_eq($sformatf("gcd_out[%0d]", inst), res[inst], e.gcd);
      if (e.cyc >= 0) check_eq($sformatf("cycles[%0d]", inst), cyc[inst], e.cyc);
      if (inst != 1) check_eq($sformatf("latency_bound[%0d] n=%0d", inst, n), n <= 2 * w + 1, 1);
      for (int i = 0; i < hold; i++) begin
        check_eq($sformatf("hold_in_ready[%0d]", inst), rdy[inst], 0);
        check_eq($sformatf("hold_out_valid[%0d]", inst), vld[inst], 1);
        check_eq($sformatf("hold_gcd[%0d]", inst), res[inst], e.gcd);
        tick();
      end
      out_ready[inst] = 1'b1;
      tick();
      out_ready[inst] = 1'b0;
      check_eq($sformatf("post_out_valid[%0d]", inst), vld[inst], 0);
      check_eq($sformatf("post_in_ready[%0d]", inst), rdy[inst], 1);
      check_eq($sformatf("retain_gcd[%0d]", inst), res[inst], e.gcd);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      a_in[i]      = '0;
      b_in[i]      = '0;
    end
    tick();
    tick();
    check_eq("rst_in_ready", rdy[0], 0);
    check_eq("rst_out_valid", vld[0], 0);
    check_eq("rst_gcd", res[0], 0);
    check_eq("rst_cycles", cyc[0], 0);
    rst = 1'b0;
    check_eq("in_ready_before_edge", rdy[0], 0);
    tick();
    for (int i = 0; i < 3; i++) check_eq($sformatf("in_ready_after_rst[%0d]", i), rdy[i], 1);

    drive(0, 16'd48, 16'd18, 1'b1, 6);
    collect(0, 0);
    drive(1, 16'd48, 16'd18, 1'b1, 5);
    collect(1, 0);
    for (int i = 0; i < 2; i++) begin
      drive(i, 16'd0, 16'd35, 1'b1, 1);
      collect(i, 0);
      drive(i, 16'd0, 16'd0, 1'b1, 1);
      collect(i, 0);
    end
    drive(2, 16'd255, 16'd255, 1'b1, 1);
    collect(2, 0);
    drive(2, 16'd128, 16'd64, 1'b1, -1);
    collect(2, 0);

    drive(0, 16'd1071, 16'd462, 1'b1, -1);
    collect(0, 10);

    for (int j = 0; j < 6; j++) begin
      drive(0, 16'($urandom), 16'($urandom), 1'b1, -1);
      collect(0, 0);
      drive(1, 16'($urandom_range(1, 300)), 16'($urandom_range(1, 300)), 1'b1, -1);
      collect(1, 0);
      drive(2, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'b1, -1);
      collect(2, 0);
    end

    // Abort a long job mid-iteration; nothing may be delivered for it.
    drive(0, 16'd1000, 16'd7, 1'b0, -1);
    in_valid[0] = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_in_ready", rdy[0], 0);
    check_eq("abort_out_valid", vld[0], 0);
    check_eq("abort_gcd", res[0], 0);
    check_eq("abort_cycles", cyc[0], 0);
    tick();
    rst = 1'b0;
    check_eq("abort_in_ready_low", rdy[0], 0);
    tick();
    check_eq("abort_in_ready_rise", rdy[0], 1);
    drive(0, 16'd12, 16'd8, 1'b1, -1);
    collect(0, 0);
    check_eq("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
